task_2_in: RTL and testbench

//  Input-side packet buffer of task 2: accepts one byte packet from the task manager,

---
 rtl/task_2_pkg.sv | 15 +
 rtl/task_2_in_fifo.sv | 42 ++++
 rtl/task_2_in.sv | 124 ++++++++++++
 tb/tb_task_2_in.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/task_2_pkg.sv
// Shared types and sizes for the task 2 input and output packet buffers.
package task_2_pkg;

  localparam int NUM_WORDS = 81;
  localparam int CNT_W     = $clog2(NUM_WORDS + 1);

  typedef enum logic [2:0] {
    s_IDLE,
    s_RECEIVE,
    s_DISCARD,
    s_FLUSH,
    s_SEND
  } task_input_enum;

endpackage

// File: rtl/task_2_in_fifo.sv
// First-word-fall-through synchronous FIFO: rd_data always shows the head entry
// while not empty; sync clear drops all contents.
module sync_fifo_fwft #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit separates full from empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/task_2_in.sv
// Task 2 input buffer: collects one manager packet, checks its length, then
// replays it to the solver with a last marker on the final word.
//
//  state     | meaning
//  s_IDLE    | one cycle between packets, FIFO known empty
//  s_RECEIVE | accepting and storing manager beats
//  s_DISCARD | packet too long, draining beats until last
//  s_FLUSH   | bad length: error pulse, FIFO cleared
//  s_SEND    | replaying stored packet to the solver
module task_2_in #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_WORDS  = 81,
  parameter int FIFO_DEPTH = 128
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_tmanager_data,
  input  logic                  i_tmanager_valid,
  input  logic                  i_tmanager_last,
  output logic                  o_tinput_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  input  logic                  i_core_ready,
  output logic                  o_input_last,
  output logic                  o_busy,
  output logic                  o_len_error
);

  import task_2_pkg::*;

  localparam int CNT_LW = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_LW-1:0] LAST_IDX = CNT_LW'(NUM_WORDS - 1);

  task_input_enum state, next;

  logic [CNT_LW-1:0]     rx_cnt;
  logic [CNT_LW-1:0]     tx_cnt;
  logic [CNT_LW-1:0]     idx;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  beat;
  logic                  wr_en;
  logic                  take;
  logic                  load;

  assign beat  = i_tmanager_valid && o_tinput_ready;
  assign wr_en = beat && (state == s_RECEIVE) && !fifo_full;
  assign take  = o_data_valid && i_core_ready;
  // Index of the word that would enter the output register this cycle.
  assign idx   = tx_cnt + CNT_LW'(take);
  assign load  = (state == s_SEND) && !fifo_empty && (!o_data_valid || i_core_ready) &&
                 (idx < CNT_LW'(NUM_WORDS));

  sync_fifo_fwft #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk    (i_clk),
    .clr    (i_rst || (state == s_FLUSH)),
    .wr_en  (wr_en),
    .wr_data(i_tmanager_data),
    .rd_en  (load),
    .rd_data(fifo_rd_data),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  always_comb begin
    next = state;
    case (state)
      s_IDLE:    next = s_RECEIVE;
      s_RECEIVE: begin
        if (beat) begin
          if (i_tmanager_last)      next = (rx_cnt == LAST_IDX) ? s_SEND : s_FLUSH;
          else if (rx_cnt == LAST_IDX) next = s_DISCARD;
        end
      end
      s_DISCARD: if (beat && i_tmanager_last) next = s_FLUSH;
      s_FLUSH:   next = s_IDLE;
      s_SEND:    if (take && o_input_last) next = s_IDLE;
      default:   next = s_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track state exactly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= s_IDLE;
      rx_cnt         <= '0;
      o_tinput_ready <= 1'b0;
      o_busy         <= 1'b0;
      o_len_error    <= 1'b0;
    end else begin
      state          <= next;
      o_tinput_ready <= (next == s_RECEIVE) || (next == s_DISCARD);
      o_busy         <= (next != s_IDLE);
      o_len_error    <= (next == s_FLUSH);
      if (wr_en)                 rx_cnt <= rx_cnt + 1'b1;
      else if (state == s_IDLE)  rx_cnt <= '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_cnt       <= '0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_input_last <= 1'b0;
    end else begin
      if (take)                 tx_cnt <= tx_cnt + 1'b1;
      else if (state == s_IDLE) tx_cnt <= '0;
      if (load) begin
        o_data       <= fifo_rd_data;
        o_data_valid <= 1'b1;
        o_input_last <= (idx == LAST_IDX);
      end else if (take) begin
        o_data_valid <= 1'b0;
        o_input_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_task_2_in.sv
// Directed bench for task_2_in: good, stalled, short, long and reset-interrupted packets.
module tb_task_2_in;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_tmanager_data;
  logic       i_tmanager_valid;
  logic       i_tmanager_last;
  logic       o_tinput_ready;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic       i_core_ready;
  logic       o_input_last;
  logic       o_busy;
  logic       o_len_error;

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  task_2_in dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_tmanager_data (i_tmanager_data),
    .i_tmanager_valid(i_tmanager_valid),
    .i_tmanager_last (i_tmanager_last),
    .o_tinput_ready  (o_tinput_ready),
    .o_data          (o_data),
    .o_data_valid    (o_data_valid),
    .i_core_ready    (i_core_ready),
    .o_input_last    (o_input_last),
    .o_busy          (o_busy),
    .o_len_error     (o_len_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_pkt(input int len, input logic [7:0] base, input bit with_last);
    for (int i = 0; i < len; i++) begin
      i_tmanager_data  = base + 8'(i);
      i_tmanager_valid = 1'b1;
      i_tmanager_last  = with_last && (i == len - 1);
      for (int g = 0; g < 20 && !o_tinput_ready; g++) step();
      chk("rx_ready", 32'(o_tinput_ready), 32'(1));
      chk("rx_no_out", 32'(o_data_valid), 32'(0));
      chk("rx_no_err", 32'(o_len_error), 32'(0));
      step();
    end
    i_tmanager_valid = 1'b0;
    i_tmanager_last  = 1'b0;
  endtask

  task automatic collect(input logic [7:0] base, input bit toggle, input int stop_at,
                         input bit hold_mgr);
    int         got = 0;
    logic [7:0] hd;
    logic       hl;
    bit         stalled;
    for (int c = 0; c < 600 && got < stop_at; c++) begin
      i_core_ready = toggle ? c[0] : 1'b1;
      stalled = o_data_valid && !i_core_ready;
      hd = o_data;
      hl = o_input_last;
      if (hold_mgr) chk("send_ready_low", 32'(o_tinput_ready), 32'(0));
      if (!toggle)  chk("no_bubble", 32'(o_data_valid), 32'(1));
      if (o_data_valid && i_core_ready) begin
        chk("word", 32'(o_data), 32'(base + 8'(got)));
        chk("last_flag", 32'(o_input_last), 32'(got == 80));
        got++;
      end
      step();
      if (stalled) begin
        chk("stall_data", 32'(o_data), 32'(hd));
        chk("stall_last", 32'(o_input_last), 32'(hl));
      end
    end
    chk("word_count", 32'(got), 32'(stop_at));
    i_core_ready = 1'b1;
  endtask

  task automatic deliver(input logic [7:0] base, input bit toggle, input int stop_at,
                         input bit hold_mgr);
    send_pkt(81, base, 1'b1);
    if (hold_mgr) begin
      i_tmanager_valid = 1'b1;
      i_tmanager_data  = 8'hEE;
    end
    chk("lat_cycle1", 32'(o_data_valid), 32'(0));
    step();
    chk("lat_cycle2", 32'(o_data_valid), 32'(1));
    collect(base, toggle, stop_at, hold_mgr);
    i_tmanager_valid = 1'b0;
    if (stop_at == 81) begin
      chk("done_busy", 32'(o_busy), 32'(0));
      chk("done_valid", 32'(o_data_valid), 32'(0));
    end
  endtask

  task automatic rst_check();
    i_rst = 1'b1;
    step();
    chk("rst_ready", 32'(o_tinput_ready), 32'(0));
    chk("rst_valid", 32'(o_data_valid), 32'(0));
    chk("rst_data", 32'(o_data), 32'(0));
    chk("rst_last", 32'(o_input_last), 32'(0));
    chk("rst_busy", 32'(o_busy), 32'(0));
    chk("rst_err", 32'(o_len_error), 32'(0));
    i_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_err", 32'(o_len_error), 32'(0));
    end
  endtask

  task automatic quiet(input int n);
    for (int k = 0; k < n; k++) begin
      chk("quiet_valid", 32'(o_data_valid), 32'(0));
      chk("quiet_err", 32'(o_len_error), 32'(0));
      step();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    i_rst            = 1'b1;
    i_tmanager_data  = '0;
    i_tmanager_valid = 1'b0;
    i_tmanager_last  = 1'b0;
    i_core_ready     = 1'b1;
    step();
    step();
    chk("init_ready", 32'(o_tinput_ready), 32'(0));
    chk("init_valid", 32'(o_data_valid), 32'(0));
    chk("init_data", 32'(o_data), 32'(0));
    chk("init_busy", 32'(o_busy), 32'(0));
    chk("init_err", 32'(o_len_error), 32'(0));
    i_rst = 1'b0;
    step();
    chk("first_recv_ready", 32'(o_tinput_ready), 32'(1));
    chk("first_recv_busy", 32'(o_busy), 32'(1));

    // 1: nominal packet, solver always ready
    deliver(8'h01, 1'b0, 81, 1'b0);
    // 2: solver alternating ready
    deliver(8'h01, 1'b1, 81, 1'b0);

    // 3: short packet, then a good one
    send_pkt(80, 8'h01, 1'b1);
    chk("short_err", 32'(o_len_error), 32'(1));
    chk("short_busy", 32'(o_busy), 32'(1));
    step();
    quiet(4);
    deliver(8'h01, 1'b0, 81, 1'b0);

    // 4: long packet, excess beats dropped
    send_pkt(90, 8'h01, 1'b1);
    chk("long_err", 32'(o_len_error), 32'(1));
    step();
    quiet(4);
    deliver(8'h40, 1'b0, 81, 1'b0);

    // 5: reset mid-receive and mid-send
    send_pkt(40, 8'h10, 1'b0);
    rst_check();
    deliver(8'h20, 1'b0, 81, 1'b0);
    deliver(8'h30, 1'b0, 20, 1'b0);
    rst_check();
    deliver(8'h50, 1'b1, 81, 1'b0);

    // 6: manager keeps valid high during send
    deliver(8'h01, 1'b0, 81, 1'b1);
    deliver(8'h60, 1'b0, 81, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
